// File: rtl/mem_line_pkg.sv
// Shared definitions for the off-chip data memory line model.
// Holds the line geometry, the FSM state encoding and the index-width helper
// used by data_memory_line and its line_ram storage.
package mem_line_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Number of index bits needed to address 'depth' lines (minimum one).
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port synchronous line storage.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (clears the read register only)
//   we    - write enable, commits wdata to mem[index]
//   re    - read enable, loads rdata from mem[index]
//   index - line index
//   wdata - line to write
//   rdata - registered read line; holds its value while re is low
module line_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] index,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
    end

    // Read register: only updates on an explicit read so the last read line is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_line.sv
// Off-chip data memory model serving 256-bit line requests from the data
// cache after a fixed latency, completing each with a one-cycle ack pulse.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset (aborts any request in flight)
//   addr_i   - byte address of the line, low offset bits ignored
//   data_i   - line to write
//   enable_i - request valid, held by the requester until ack_o
//   write_i  - 1 = write line, 0 = read line
//   ack_o    - one-cycle completion pulse
//   data_o   - read line, valid in the ack_o cycle and held until the next read
module data_memory_line #(
    parameter int LINE_WIDTH = mem_line_pkg::LINE_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [LINE_WIDTH-1:0] data_o
);

    import mem_line_pkg::*;

    localparam int         IDX_W      = index_width(DEPTH);
    localparam logic [7:0] LAT_M1     = 8'(LATENCY - 1);
    localparam bit         DIRECT_ACK = (LATENCY == 1);

    state_e                state_r;
    state_e                state_s;
    logic [7:0]            count_r;
    logic [7:0]            count_s;
    logic [IDX_W-1:0]      req_index_r;
    logic [LINE_WIDTH-1:0] req_data_r;
    logic                  req_write_r;
    logic                  ack_r;
    logic                  accept_s;
    logic                  is_read_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [IDX_W-1:0]      addr_index_s;
    logic [IDX_W-1:0]      ram_index_s;
    logic                  unused_addr_s;

    // Upper address bits alias modulo DEPTH lines; offset bits select nothing.
    assign addr_index_s  = addr_i[OFFSET_BITS +: IDX_W];
    assign unused_addr_s = ^addr_i;

    // Next-state and counter logic for the request FSM.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable_i) begin
                    accept_s = 1'b1;
                    count_s  = LAT_M1;
                    if (DIRECT_ACK) begin
                        state_s = ACK;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                count_s = count_r - 8'd1;
                if (count_r == 8'd1) begin
                    state_s = ACK;
                end else begin
                    state_s = WAIT;
                end
            end
            ACK: begin
                // A still-high enable here belongs to the finished request.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                count_s = 8'd0;
            end
        endcase
    end

    // RAM control: the read is issued on the edge entering ACK so data_o is
    // valid in the ack cycle; in IDLE the live address is used because a
    // single-cycle latency enters ACK on the accepting edge itself.
    always_comb begin
        if (state_r == IDLE) begin
            ram_index_s = addr_index_s;
            is_read_s   = ~write_i;
        end else begin
            ram_index_s = req_index_r;
            is_read_s   = ~req_write_r;
        end
        ram_re_s = ~rst_i && (state_s == ACK) && (state_r != ACK) && is_read_s;
        // Writes commit on the edge ending ACK unless reset aborts them.
        ram_we_s = ~rst_i && (state_r == ACK) && req_write_r;
    end

    // State, counter, request latches and registered ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            count_r     <= 8'd0;
            ack_r       <= 1'b0;
            req_index_r <= {IDX_W{1'b0}};
            req_data_r  <= {LINE_WIDTH{1'b0}};
            req_write_r <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            ack_r   <= (state_s == ACK);
            if (accept_s) begin
                req_index_r <= addr_index_s;
                req_data_r  <= data_i;
                req_write_r <= write_i;
            end
        end
    end

    line_ram #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_line_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .index (ram_index_s),
        .wdata (req_data_r),
        .rdata (data_o)
    );

    assign ack_o = ack_r;

endmodule

// File: tb/tb_data_memory_line.sv
// Self-checking bench for data_memory_line. Two instances are exercised: one
// with LATENCY=10 and one with LATENCY=1. A line-array model indexed by
// (address / 32) mod 512 predicts read data, held data_o and ack timing.
module tb_data_memory_line;

    localparam int LAT0 = 10;
    localparam int LAT1 = 1;
    localparam int LW   = 256;

    logic          clk = 1'b0;
    logic          rst  [2];
    logic          en   [2];
    logic          wr   [2];
    logic [31:0]   ad   [2];
    logic [LW-1:0] di   [2];
    logic          ack  [2];
    logic [LW-1:0] dout [2];

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] mem_m   [2][512];
    bit            valid_m [2][512];
    logic [LW-1:0] last_rd [2];

    always #5 clk = ~clk;

    data_memory_line #(.LINE_WIDTH(LW), .ADDR_WIDTH(32), .DEPTH(512), .LATENCY(LAT0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .addr_i(ad[0]), .data_i(di[0]),
        .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(dout[0])
    );

    data_memory_line #(.LINE_WIDTH(LW), .ADDR_WIDTH(32), .DEPTH(512), .LATENCY(LAT1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .addr_i(ad[1]), .data_i(di[1]),
        .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(dout[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd32) % 32'd512);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request and wait (bounded) for its ack; lat counts cycles
    // from the first edge after the request is presented to the ack cycle.
    task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [LW-1:0] data,
                         input bit mutate, output int lat, output logic [LW-1:0] rd);
        @(negedge clk);
        en[d] = 1'b1; wr[d] = w; ad[d] = a; di[d] = data;
        @(posedge clk); #1;
        lat = 1;
        if (mutate) begin
            ad[d] = 32'h0000_0060; di[d] = ~data; wr[d] = ~w;
        end
        while (!ack[d] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = dout[d];
    endtask

    // Drop enable during the ack cycle and confirm the pulse lasted one cycle.
    task automatic release_bus(input int d);
        @(negedge clk);
        en[d] = 1'b0; wr[d] = 1'($urandom);
        @(posedge clk); #1;
        check_eq($sformatf("ack_width d%0d", d), LW'(ack[d]), LW'(0));
    endtask

    // Full request with model-based checking of latency and data_o.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [LW-1:0] data,
                       input int exp_lat, input string tag);
        int lat;
        logic [LW-1:0] rd;
        logic [LW-1:0] exp_rd;
        issue(d, w, a, data, 1'b0, lat, rd);
        check_eq($sformatf("%s_lat d%0d", tag, d), LW'(lat), LW'(exp_lat));
        exp_rd = w ? last_rd[d] : mem_m[d][line_of(a)];
        check_eq($sformatf("%s_data d%0d", tag, d), rd, exp_rd);
        if (w) begin
            mem_m[d][line_of(a)]   = data;
            valid_m[d][line_of(a)] = 1'b1;
        end else begin
            last_rd[d] = exp_rd;
        end
    endtask

    initial begin
        logic [LW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, rd;
        int lat, cnt, waits;
        int lines [8] = '{3, 4, 2, 1, 0, 100, 511, 257};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; di[d] = '0;
            last_rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset_ack d%0d", d), LW'(ack[d]), LW'(0));
            check_eq($sformatf("reset_data d%0d", d), dout[d], LW'(0));
            rst[d] = 1'b0;
        end

        for (int d = 0; d < 2; d++) begin
            pat_a = rand_line(); pat_b = rand_line(); pat_c = rand_line();
            pat_d = rand_line(); pat_e = rand_line(); pat_f = rand_line();

            // Preload line 3, read it back.
            txn(d, 1'b1, 32'h60, pat_a, lat_of(d), "preload"); release_bus(d);
            txn(d, 1'b0, 32'h60, '0, lat_of(d), "read_a");     release_bus(d);
            // Write B: data_o must keep A during the write ack.
            txn(d, 1'b1, 32'h80, pat_b, lat_of(d), "write_b"); release_bus(d);
            txn(d, 1'b0, 32'h80, '0, lat_of(d), "read_b");     release_bus(d);

            // Enable held across ACK: next request accepted one cycle later.
            txn(d, 1'b1, 32'h40, pat_d, lat_of(d), "chain_w");
            txn(d, 1'b0, 32'h40, '0, lat_of(d) + 1, "chain_r");
            release_bus(d);

            // Inputs changed after acceptance must not affect the write.
            issue(d, 1'b1, 32'h20, pat_e, 1'b1, lat, rd);
            check_eq($sformatf("mutate_lat d%0d", d), LW'(lat), LW'(lat_of(d)));
            mem_m[d][1] = pat_e; valid_m[d][1] = 1'b1;
            release_bus(d);
            txn(d, 1'b0, 32'h20, '0, lat_of(d), "mutate_l1"); release_bus(d);
            txn(d, 1'b0, 32'h60, '0, lat_of(d), "mutate_l3"); release_bus(d);

            // Reset in WAIT cycle 5 (or in ACK for single-cycle latency).
            @(negedge clk);
            en[d] = 1'b1; wr[d] = 1'b1; ad[d] = 32'h40; di[d] = pat_f;
            @(posedge clk); #1;
            waits = (lat_of(d) > 5) ? 5 : lat_of(d);
            for (int i = 1; i < waits; i++) begin
                @(posedge clk); #1;
            end
            rst[d] = 1'b1; en[d] = 1'b0;
            @(posedge clk); #1;
            rst[d] = 1'b0;
            check_eq($sformatf("abort_ack d%0d", d), LW'(ack[d]), LW'(0));
            check_eq($sformatf("abort_data d%0d", d), dout[d], LW'(0));
            last_rd[d] = '0;
            cnt = 0;
            repeat (lat_of(d) + 3) begin
                @(posedge clk); #1;
                if (ack[d]) cnt++;
            end
            check_eq($sformatf("abort_noack d%0d", d), LW'(cnt), LW'(0));
            txn(d, 1'b0, 32'h40, '0, lat_of(d), "abort_old"); release_bus(d);

            // Address aliasing modulo 512 lines.
            txn(d, 1'b1, 32'h4000, pat_c, lat_of(d), "alias_w"); release_bus(d);
            txn(d, 1'b0, 32'h0, '0, lat_of(d), "alias_r");       release_bus(d);
        end

        // Randomized traffic over a few lines with aliased upper bits.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                int ln;
                bit w;
                logic [31:0] a;
                ln = lines[$urandom_range(0, 7)];
                a  = ($urandom_range(0, 3) << 14) | (ln << 5) | $urandom_range(0, 31);
                w  = 1'($urandom_range(0, 1));
                if (!valid_m[d][ln]) w = 1'b1;
                txn(d, w, a, rand_line(), lat_of(d), w ? "rnd_w" : "rnd_r");
                release_bus(d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
